// File: rtl/cache_bus_arbiter_pkg.sv
// Shared definitions for the cache bus arbiter.
// Holds the FSM and grant encodings, the sram-like field widths and the
// arbitration decision so that every file agrees on one definition.
package cache_bus_arbiter_pkg;

  localparam int SIZE_W = 2;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ADDR = 2'b01,
    WAIT = 2'b10
  } arb_state_e;

  typedef enum logic {
    GNT_INST = 1'b0,
    GNT_DATA = 1'b1
  } gnt_e;

  // Winner among the requesting masters.
  // Only meaningful when at least one request is high.
  // Fixed mode: data beats inst.
  // Round-robin mode: on a tie the master that was not served last wins.
  function automatic gnt_e arb_pick(input logic inst_req,
                                    input logic data_req,
                                    input logic rr_mode,
                                    input gnt_e last);
    gnt_e win;
    if (inst_req && data_req) begin
      if (rr_mode) begin
        win = (last == GNT_INST) ? GNT_DATA : GNT_INST;
      end else begin
        win = GNT_DATA;
      end
    end else if (data_req) begin
      win = GNT_DATA;
    end else begin
      win = GNT_INST;
    end
    return win;
  endfunction

endpackage

// File: rtl/cache_bus_arbiter_if.sv
// Sram-like bus bundle.
// The master modport is the side that issues requests:
//   it drives req/wr/size/addr/wdata and receives rdata/addr_ok/data_ok.
// The slave modport is the side that answers them.
interface cache_bus_arbiter_if;
  import cache_bus_arbiter_pkg::*;

  logic              req;
  logic              wr;
  logic [SIZE_W-1:0] size;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              addr_ok;
  logic              data_ok;

  modport master (
    output req, wr, size, addr, wdata,
    input  rdata, addr_ok, data_ok
  );

  modport slave (
    input  req, wr, size, addr, wdata,
    output rdata, addr_ok, data_ok
  );

endinterface

// File: rtl/cache_bus_arbiter_sram_like_mux2.sv
// Combinational 2:1 mux of the sram-like request fields.
// Ports:
//   sel                     grant (GNT_INST / GNT_DATA)
//   inst_* / data_*         request fields of the two masters
//   out_*                   fields of the selected master
module sram_like_mux2
  import cache_bus_arbiter_pkg::*;
(
  input  gnt_e              sel,
  input  logic              inst_req,
  input  logic              inst_wr,
  input  logic [SIZE_W-1:0] inst_size,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic [DATA_W-1:0] inst_wdata,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [SIZE_W-1:0] data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              out_req,
  output logic              out_wr,
  output logic [SIZE_W-1:0] out_size,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_wdata
);

  always_comb begin
    out_req   = inst_req;
    out_wr    = inst_wr;
    out_size  = inst_size;
    out_addr  = inst_addr;
    out_wdata = inst_wdata;
    if (sel == GNT_DATA) begin
      out_req   = data_req;
      out_wr    = data_wr;
      out_size  = data_size;
      out_addr  = data_addr;
      out_wdata = data_wdata;
    end
  end

endmodule

// File: rtl/cache_bus_arbiter.sv
// Two-master to one-slave arbiter for sram-like buses.
// Shares one sram-like port (toward the AXI bridge) between the I-cache
// and D-cache miss ports. One transaction is outstanding at a time and
// the grant stays locked until the slave returns data_ok.
//
// Parameters:
//   ARB_MODE    0 = fixed priority (data over inst), 1 = round-robin
//   RESET_LAST  last-grant value after reset (0 = inst, 1 = data)
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   cache_inst  I-cache miss port (this block is its slave)
//   cache_data  D-cache miss port (this block is its slave)
//   bus         shared port toward the slave (this block is its master)
//   busy        high whenever a transaction owns the bus
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no owner; arbitrate among requests, nothing driven on the bus
// ADDR  | granted master's request presented, waiting for bus_addr_ok
// WAIT  | address accepted, waiting for bus_data_ok
module cache_bus_arbiter
  import cache_bus_arbiter_pkg::*;
#(
  parameter int ARB_MODE   = 0,
  parameter int RESET_LAST = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  cache_bus_arbiter_if.slave         cache_inst,
  cache_bus_arbiter_if.slave         cache_data,
  cache_bus_arbiter_if.master        bus,
  output logic                       busy
);

  localparam logic RR_MODE   = (ARB_MODE != 0);
  localparam gnt_e LAST_INIT = (RESET_LAST != 0) ? GNT_DATA : GNT_INST;

  arb_state_e state_q, state_d;
  gnt_e       gnt_q, gnt_d;
  gnt_e       last_q, last_d;

  logic              mux_req;
  logic              mux_wr;
  logic [SIZE_W-1:0] mux_size;
  logic [ADDR_W-1:0] mux_addr;
  logic [DATA_W-1:0] mux_wdata;

  logic bus_req_c;
  logic addr_ok_c;
  logic data_ok_c;

  sram_like_mux2 u_mux (
    .sel        (gnt_q),
    .inst_req   (cache_inst.req),
    .inst_wr    (cache_inst.wr),
    .inst_size  (cache_inst.size),
    .inst_addr  (cache_inst.addr),
    .inst_wdata (cache_inst.wdata),
    .data_req   (cache_data.req),
    .data_wr    (cache_data.wr),
    .data_size  (cache_data.size),
    .data_addr  (cache_data.addr),
    .data_wdata (cache_data.wdata),
    .out_req    (mux_req),
    .out_wr     (mux_wr),
    .out_size   (mux_size),
    .out_addr   (mux_addr),
    .out_wdata  (mux_wdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= GNT_INST;
      last_q  <= LAST_INIT;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    last_d    = last_q;
    bus_req_c = 1'b0;
    addr_ok_c = 1'b0;
    data_ok_c = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cache_inst.req || cache_data.req) begin
          gnt_d   = arb_pick(cache_inst.req, cache_data.req, RR_MODE, last_q);
          state_d = ADDR;
        end
      end

      ADDR: begin
        bus_req_c = mux_req;
        if (mux_req && bus.addr_ok) begin
          addr_ok_c = 1'b1;
          last_d    = gnt_q;
          // A slave may finish in the accepting cycle; skip WAIT then.
          if (bus.data_ok) begin
            data_ok_c = 1'b1;
            state_d   = IDLE;
          end else begin
            state_d   = WAIT;
          end
        end else if (!mux_req) begin
          // Request withdrawn before acceptance: drop it, nothing was issued.
          state_d = IDLE;
        end
      end

      WAIT: begin
        if (bus.data_ok) begin
          data_ok_c = 1'b1;
          state_d   = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy = (state_q != IDLE);

  // Fields are held at zero while idle so nothing stale leaks out after reset.
  assign bus.req   = bus_req_c;
  assign bus.wr    = busy & mux_wr;
  assign bus.size  = {SIZE_W{busy}} & mux_size;
  assign bus.addr  = {ADDR_W{busy}} & mux_addr;
  assign bus.wdata = {DATA_W{busy}} & mux_wdata;

  assign cache_inst.addr_ok = addr_ok_c & (gnt_q == GNT_INST);
  assign cache_inst.data_ok = data_ok_c & (gnt_q == GNT_INST);
  assign cache_data.addr_ok = addr_ok_c & (gnt_q == GNT_DATA);
  assign cache_data.data_ok = data_ok_c & (gnt_q == GNT_DATA);

  assign cache_inst.rdata = bus.rdata;
  assign cache_data.rdata = bus.rdata;

endmodule

// File: tb/tb_cache_bus_arbiter.sv
module tb_cache_bus_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic sel = 1'b0;  // 0: fixed-priority instance, 1: round-robin instance

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        i_req, i_wr, d_req, d_wr;
  logic [1:0]  i_size, d_size;
  logic [31:0] i_addr, i_wdata, d_addr, d_wdata;
  logic        s_addr_ok, s_data_ok;
  logic [31:0] s_rdata;

  cache_bus_arbiter_if inst_if0 ();
  cache_bus_arbiter_if data_if0 ();
  cache_bus_arbiter_if bus_if0 ();
  cache_bus_arbiter_if inst_if1 ();
  cache_bus_arbiter_if data_if1 ();
  cache_bus_arbiter_if bus_if1 ();
  logic busy0, busy1;

  assign inst_if0.req = i_req & ~sel;   assign inst_if1.req = i_req & sel;
  assign inst_if0.wr = i_wr;            assign inst_if1.wr = i_wr;
  assign inst_if0.size = i_size;        assign inst_if1.size = i_size;
  assign inst_if0.addr = i_addr;        assign inst_if1.addr = i_addr;
  assign inst_if0.wdata = i_wdata;      assign inst_if1.wdata = i_wdata;
  assign data_if0.req = d_req & ~sel;   assign data_if1.req = d_req & sel;
  assign data_if0.wr = d_wr;            assign data_if1.wr = d_wr;
  assign data_if0.size = d_size;        assign data_if1.size = d_size;
  assign data_if0.addr = d_addr;        assign data_if1.addr = d_addr;
  assign data_if0.wdata = d_wdata;      assign data_if1.wdata = d_wdata;
  assign bus_if0.addr_ok = s_addr_ok & ~sel;  assign bus_if1.addr_ok = s_addr_ok & sel;
  assign bus_if0.data_ok = s_data_ok & ~sel;  assign bus_if1.data_ok = s_data_ok & sel;
  assign bus_if0.rdata = s_rdata;             assign bus_if1.rdata = s_rdata;

  cache_bus_arbiter #(.ARB_MODE(0), .RESET_LAST(0)) dut_fp (
    .clk(clk), .rst(rst), .cache_inst(inst_if0), .cache_data(data_if0), .bus(bus_if0), .busy(busy0));
  cache_bus_arbiter #(.ARB_MODE(1), .RESET_LAST(0)) dut_rr (
    .clk(clk), .rst(rst), .cache_inst(inst_if1), .cache_data(data_if1), .bus(bus_if1), .busy(busy1));

  logic        o_busy, o_bus_req, o_bus_wr;
  logic [1:0]  o_bus_size;
  logic [31:0] o_bus_addr, o_bus_wdata;
  logic        o_i_addr_ok, o_i_data_ok, o_d_addr_ok, o_d_data_ok;
  logic [31:0] o_i_rdata, o_d_rdata;
  logic [66:0] o_fields;

  assign o_busy      = sel ? busy1 : busy0;
  assign o_bus_req   = sel ? bus_if1.req : bus_if0.req;
  assign o_bus_wr    = sel ? bus_if1.wr : bus_if0.wr;
  assign o_bus_size  = sel ? bus_if1.size : bus_if0.size;
  assign o_bus_addr  = sel ? bus_if1.addr : bus_if0.addr;
  assign o_bus_wdata = sel ? bus_if1.wdata : bus_if0.wdata;
  assign o_i_addr_ok = sel ? inst_if1.addr_ok : inst_if0.addr_ok;
  assign o_i_data_ok = sel ? inst_if1.data_ok : inst_if0.data_ok;
  assign o_i_rdata   = sel ? inst_if1.rdata : inst_if0.rdata;
  assign o_d_addr_ok = sel ? data_if1.addr_ok : data_if0.addr_ok;
  assign o_d_data_ok = sel ? data_if1.data_ok : data_if0.data_ok;
  assign o_d_rdata   = sel ? data_if1.rdata : data_if0.rdata;
  assign o_fields    = {o_bus_wr, o_bus_size, o_bus_addr, o_bus_wdata};

  task automatic clear_inputs();
    i_req = 0; i_wr = 0; i_size = 0; i_addr = 0; i_wdata = 0;
    d_req = 0; d_wr = 0; d_size = 0; d_addr = 0; d_wdata = 0;
    s_addr_ok = 0; s_data_ok = 0; s_rdata = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      @(negedge clk);
      rst = 1'b1;
      i_req = 1; d_req = 1; i_addr = 32'h1234; d_addr = 32'h5678; d_wr = 1;
      s_addr_ok = 1; s_data_ok = 1;
      #1;
      checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy sel=%0d got=%0h exp=0", s, o_busy); end
      checks++; if (o_bus_req !== 1'b0) begin errors++; $display("FAIL reset_bus_req sel=%0d got=%0h exp=0", s, o_bus_req); end
      checks++; if (o_fields !== 67'd0) begin errors++; $display("FAIL reset_fields sel=%0d got=%0h exp=0", s, o_fields); end
      checks++; if ({o_i_addr_ok, o_i_data_ok, o_d_addr_ok, o_d_data_ok} !== 4'b0)
        begin errors++; $display("FAIL reset_oks sel=%0d got=%b exp=0000", s, {o_i_addr_ok, o_i_data_ok, o_d_addr_ok, o_d_data_ok}); end
      @(negedge clk);
      clear_inputs();
      rst = 1'b0;
      @(negedge clk);
      #1;
      checks++; if ({o_busy, o_bus_req, o_fields} !== 69'd0)
        begin errors++; $display("FAIL post_reset_idle sel=%0d got=%0h exp=0", s, {o_busy, o_bus_req, o_fields}); end
    end
  endtask

  task automatic test_single_inst_read();
    sel = 0; do_reset();
    @(negedge clk); i_req = 1; i_addr = 32'hBFC0_0000; i_size = 2; #1;
    checks++; if ({o_busy, o_bus_req} !== 2'b00) begin errors++; $display("FAIL sir_c0 got=%b exp=00", {o_busy, o_bus_req}); end
    @(negedge clk); #1;
    checks++; if ({o_bus_req, o_i_addr_ok} !== 2'b10) begin errors++; $display("FAIL sir_c1_req got=%b exp=10", {o_bus_req, o_i_addr_ok}); end
    checks++; if (o_bus_addr !== 32'hBFC0_0000) begin errors++; $display("FAIL sir_c1_addr got=%h exp=bfc00000", o_bus_addr); end
    @(negedge clk); s_addr_ok = 1; #1;
    checks++; if ({o_bus_req, o_i_addr_ok, o_d_addr_ok} !== 3'b110)
      begin errors++; $display("FAIL sir_c2_addr_ok got=%b exp=110", {o_bus_req, o_i_addr_ok, o_d_addr_ok}); end
    @(negedge clk); i_req = 0; s_addr_ok = 0; #1;
    checks++; if ({o_busy, o_bus_req, o_i_data_ok} !== 3'b100)
      begin errors++; $display("FAIL sir_c3_wait got=%b exp=100", {o_busy, o_bus_req, o_i_data_ok}); end
    checks++; if (o_bus_addr !== 32'hBFC0_0000) begin errors++; $display("FAIL sir_c3_addr got=%h exp=bfc00000", o_bus_addr); end
    @(negedge clk); s_data_ok = 1; s_rdata = 32'h3C08_0001; #1;
    checks++; if ({o_i_data_ok, o_d_data_ok, o_i_addr_ok} !== 3'b100)
      begin errors++; $display("FAIL sir_c4_data_ok got=%b exp=100", {o_i_data_ok, o_d_data_ok, o_i_addr_ok}); end
    checks++; if (o_i_rdata !== 32'h3C08_0001) begin errors++; $display("FAIL sir_c4_rdata got=%h exp=3c080001", o_i_rdata); end
    @(negedge clk); s_data_ok = 0; #1;
    checks++; if ({o_busy, o_bus_req, o_i_data_ok} !== 3'b000)
      begin errors++; $display("FAIL sir_c5_idle got=%b exp=000", {o_busy, o_bus_req, o_i_data_ok}); end
    clear_inputs();
  endtask

  task automatic test_fixed_priority();
    sel = 0; do_reset();
    @(negedge clk); i_req = 1; i_addr = 32'h100; d_req = 1; d_addr = 32'h8000; #1;
    @(negedge clk); s_addr_ok = 1; #1;
    checks++; if (o_bus_addr !== 32'h8000) begin errors++; $display("FAIL fp_first_addr got=%h exp=8000", o_bus_addr); end
    checks++; if ({o_d_addr_ok, o_i_addr_ok} !== 2'b10) begin errors++; $display("FAIL fp_first_aok got=%b exp=10", {o_d_addr_ok, o_i_addr_ok}); end
    @(negedge clk); d_req = 0; s_addr_ok = 0; s_data_ok = 1; s_rdata = 32'hA5A5_0001; #1;
    checks++; if ({o_d_data_ok, o_i_data_ok, o_i_addr_ok} !== 3'b100)
      begin errors++; $display("FAIL fp_first_dok got=%b exp=100", {o_d_data_ok, o_i_data_ok, o_i_addr_ok}); end
    @(negedge clk); s_data_ok = 0; #1;
    checks++; if ({o_busy, o_bus_req} !== 2'b00) begin errors++; $display("FAIL fp_gap got=%b exp=00", {o_busy, o_bus_req}); end
    @(negedge clk); s_addr_ok = 1; s_data_ok = 1; #1;
    checks++; if ({o_bus_req, o_bus_addr} !== {1'b1, 32'h100}) begin errors++; $display("FAIL fp_second got=%h exp=1_00000100", {o_bus_req, o_bus_addr}); end
    checks++; if ({o_i_addr_ok, o_i_data_ok, o_d_addr_ok, o_d_data_ok} !== 4'b1100)
      begin errors++; $display("FAIL fp_second_oks got=%b exp=1100", {o_i_addr_ok, o_i_data_ok, o_d_addr_ok, o_d_data_ok}); end
    @(negedge clk); clear_inputs();
  endtask

  task automatic test_round_robin();
    logic exp_data;
    sel = 1; do_reset();
    i_addr = 32'h100; d_addr = 32'h8000;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); i_req = 1; d_req = 1; s_addr_ok = 0; s_data_ok = 0; #1;
      checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL rr_idle k=%0d got=%0h exp=0", k, o_busy); end
      @(negedge clk); s_addr_ok = 1; s_data_ok = 1; s_rdata = 32'(k); #1;
      exp_data = (k % 2 == 0);
      checks++; if (o_bus_addr !== (exp_data ? 32'h8000 : 32'h100))
        begin errors++; $display("FAIL rr_grant k=%0d got=%h exp=%h", k, o_bus_addr, exp_data ? 32'h8000 : 32'h100); end
      checks++; if ({o_d_addr_ok, o_d_data_ok, o_i_addr_ok, o_i_data_ok} !== {exp_data, exp_data, ~exp_data, ~exp_data})
        begin errors++; $display("FAIL rr_oks k=%0d got=%b exp=%b", k, {o_d_addr_ok, o_d_data_ok, o_i_addr_ok, o_i_data_ok}, {exp_data, exp_data, ~exp_data, ~exp_data}); end
    end
    @(negedge clk); clear_inputs();
  endtask

  task automatic test_data_write();
    sel = 0; do_reset();
    @(negedge clk); d_req = 1; d_wr = 1; d_size = 2; d_addr = 32'h10; d_wdata = 32'hDEAD_BEEF; #1;
    @(negedge clk); s_addr_ok = 1; #1;
    checks++; if (o_fields !== {1'b1, 2'd2, 32'h10, 32'hDEAD_BEEF})
      begin errors++; $display("FAIL wr_fields got=%h exp=%h", o_fields, {1'b1, 2'd2, 32'h10, 32'hDEAD_BEEF}); end
    checks++; if ({o_bus_req, o_d_addr_ok} !== 2'b11) begin errors++; $display("FAIL wr_aok got=%b exp=11", {o_bus_req, o_d_addr_ok}); end
    @(negedge clk); d_req = 0; s_addr_ok = 0; #1;
    checks++; if (o_d_data_ok !== 1'b0) begin errors++; $display("FAIL wr_early_dok got=%0h exp=0", o_d_data_ok); end
    @(negedge clk); s_data_ok = 1; #1;
    checks++; if ({o_d_data_ok, o_i_data_ok} !== 2'b10) begin errors++; $display("FAIL wr_dok got=%b exp=10", {o_d_data_ok, o_i_data_ok}); end
    @(negedge clk); clear_inputs();
  endtask

  task automatic test_same_cycle_ok();
    sel = 0; do_reset();
    @(negedge clk); i_req = 1; i_addr = 32'h40; #1;
    @(negedge clk); s_addr_ok = 1; s_data_ok = 1; s_rdata = 32'h1357_9BDF; #1;
    checks++; if ({o_i_addr_ok, o_i_data_ok} !== 2'b11) begin errors++; $display("FAIL same_both got=%b exp=11", {o_i_addr_ok, o_i_data_ok}); end
    checks++; if (o_i_rdata !== 32'h1357_9BDF) begin errors++; $display("FAIL same_rdata got=%h exp=13579bdf", o_i_rdata); end
    @(negedge clk); i_req = 0; d_req = 1; d_addr = 32'h80; s_addr_ok = 0; s_data_ok = 0; #1;
    checks++; if ({o_busy, o_bus_req} !== 2'b00) begin errors++; $display("FAIL same_idle got=%b exp=00", {o_busy, o_bus_req}); end
    @(negedge clk); #1;
    checks++; if ({o_bus_req, o_bus_addr} !== {1'b1, 32'h80}) begin errors++; $display("FAIL same_next got=%h exp=1_00000080", {o_bus_req, o_bus_addr}); end
    s_addr_ok = 1; s_data_ok = 1;
    @(negedge clk); clear_inputs();
  endtask

  task automatic test_async_reset_in_wait();
    sel = 0; do_reset();
    @(negedge clk); i_req = 1; i_addr = 32'h200; #1;
    @(negedge clk); s_addr_ok = 1; #1;
    @(negedge clk); s_addr_ok = 0; #1;
    checks++; if ({o_busy, o_bus_req} !== 2'b10) begin errors++; $display("FAIL ar_in_wait got=%b exp=10", {o_busy, o_bus_req}); end
    #2 rst = 1'b1; s_data_ok = 1; #1;
    checks++; if ({o_busy, o_bus_req, o_i_addr_ok, o_i_data_ok, o_d_addr_ok, o_d_data_ok} !== 6'b0)
      begin errors++; $display("FAIL ar_async got=%b exp=000000", {o_busy, o_bus_req, o_i_addr_ok, o_i_data_ok, o_d_addr_ok, o_d_data_ok}); end
    @(negedge clk); s_data_ok = 0;
    @(negedge clk); rst = 1'b0; #1;
    checks++; if ({o_busy, o_bus_req} !== 2'b00) begin errors++; $display("FAIL ar_release got=%b exp=00", {o_busy, o_bus_req}); end
    @(negedge clk); #1;
    checks++; if ({o_bus_req, o_bus_addr} !== {1'b1, 32'h200}) begin errors++; $display("FAIL ar_regrant got=%h exp=1_00000200", {o_bus_req, o_bus_addr}); end
    s_addr_ok = 1; s_data_ok = 1; #1;
    checks++; if ({o_i_addr_ok, o_i_data_ok} !== 2'b11) begin errors++; $display("FAIL ar_complete got=%b exp=11", {o_i_addr_ok, o_i_data_ok}); end
    @(negedge clk); clear_inputs();
  endtask

  // Random masters and a random-latency slave against a transaction-level model:
  // owner = master holding the bus (-1 none), accepted = its address was taken.
  task automatic test_random(input logic which, input int n);
    bit          pend [2];
    bit          outst [2];
    logic        m_wr [2];
    logic [1:0]  m_size [2];
    logic [31:0] m_addr [2];
    logic [31:0] m_wdata [2];
    int owner, last, sl_cnt, sl_acnt, lat;
    bit accepted, sl_busy, hs, done;
    logic exp_busy, exp_req, exp_ao, exp_do, got_ao, got_do;
    logic [31:0] got_rd;
    logic [66:0] exp_f;
    sel = which; do_reset();
    owner = -1; accepted = 0; last = 0; sl_busy = 0; sl_cnt = 0; lat = 0;
    sl_acnt = $urandom_range(0, 2);
    for (int m = 0; m < 2; m++) begin
      pend[m] = 0; outst[m] = 0; m_wr[m] = 0; m_size[m] = 0; m_addr[m] = 0; m_wdata[m] = 0;
    end
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      for (int m = 0; m < 2; m++) begin
        if (!pend[m] && !outst[m] && $urandom_range(0, 2) == 0) begin
          pend[m] = 1; m_wr[m] = 1'($urandom_range(0, 1)); m_size[m] = 2'($urandom_range(0, 2));
          m_addr[m] = $urandom; m_wdata[m] = $urandom;
        end
      end
      i_req = pend[0]; i_wr = m_wr[0]; i_size = m_size[0]; i_addr = m_addr[0]; i_wdata = m_wdata[0];
      d_req = pend[1]; d_wr = m_wr[1]; d_size = m_size[1]; d_addr = m_addr[1]; d_wdata = m_wdata[1];
      s_addr_ok = 0; s_data_ok = 0; s_rdata = $urandom;
      #1;
      if (sl_busy) begin
        if (sl_cnt == 0) s_data_ok = 1;
      end else if (o_bus_req && sl_acnt == 0) begin
        s_addr_ok = 1; lat = $urandom_range(0, 3);
        if (lat == 0) s_data_ok = 1;
      end
      if (!sl_busy && !s_addr_ok && $urandom_range(0, 7) == 0) s_data_ok = 1;
      #1;
      hs   = (owner >= 0) && !accepted && s_addr_ok;
      done = (owner >= 0) && s_data_ok && (accepted || hs);
      exp_busy = (owner >= 0);
      exp_req  = (owner >= 0) && !accepted;
      exp_f    = (owner >= 0) ? {m_wr[owner], m_size[owner], m_addr[owner], m_wdata[owner]} : 67'd0;
      checks++; if (o_busy !== exp_busy) begin errors++; $display("FAIL rnd_busy sel=%0d cyc=%0d got=%0h exp=%0h", which, c, o_busy, exp_busy); end
      checks++; if (o_bus_req !== exp_req) begin errors++; $display("FAIL rnd_bus_req sel=%0d cyc=%0d got=%0h exp=%0h", which, c, o_bus_req, exp_req); end
      checks++; if (o_fields !== exp_f) begin errors++; $display("FAIL rnd_fields sel=%0d cyc=%0d got=%h exp=%h", which, c, o_fields, exp_f); end
      for (int m = 0; m < 2; m++) begin
        got_ao = (m == 0) ? o_i_addr_ok : o_d_addr_ok;
        got_do = (m == 0) ? o_i_data_ok : o_d_data_ok;
        got_rd = (m == 0) ? o_i_rdata : o_d_rdata;
        exp_ao = hs && (owner == m);
        exp_do = done && (owner == m);
        checks++; if ({got_ao, got_do} !== {exp_ao, exp_do})
          begin errors++; $display("FAIL rnd_oks sel=%0d cyc=%0d m=%0d got=%b exp=%b", which, c, m, {got_ao, got_do}, {exp_ao, exp_do}); end
        if (exp_do) begin
          checks++; if (got_rd !== s_rdata) begin errors++; $display("FAIL rnd_rdata sel=%0d cyc=%0d m=%0d got=%h exp=%h", which, c, m, got_rd, s_rdata); end
        end
      end
      if (sl_busy) begin
        if (s_data_ok) sl_busy = 0; else sl_cnt--;
      end else if (s_addr_ok) begin
        sl_acnt = $urandom_range(0, 2);
        if (lat != 0) begin sl_busy = 1; sl_cnt = lat - 1; end
      end else if (o_bus_req && sl_acnt > 0) begin
        sl_acnt--;
      end
      if (owner < 0) begin
        if (pend[0] || pend[1]) begin
          if (pend[0] && pend[1]) owner = which ? (1 - last) : 1;
          else owner = pend[1] ? 1 : 0;
          accepted = 0;
        end
      end else begin
        if (hs) begin last = owner; pend[owner] = 0; outst[owner] = 1; accepted = 1; end
        if (done) begin outst[owner] = 0; owner = -1; accepted = 0; end
      end
    end
    @(negedge clk); clear_inputs();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_single_inst_read();
    test_fixed_priority();
    test_round_robin();
    test_data_write();
    test_same_cycle_ok();
    test_async_reset_in_wait();
    test_random(1'b0, 600);
    test_random(1'b1, 600);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
